// File: rtl/alu_sequencer.sv
// Drives the shared 16-bit ALU for single-pass add/subtract and 16-step multiply/divide loops.
// Optional overflow flagging is enabled by defining ALU_SEQ_OVF_EN.
module alu_sequencer #(
   parameter logic [3:0] OP_PLUS  = 4'hC,
   parameter logic [3:0] OP_MINUS = 4'hD,
   parameter logic [3:0] OP_MULT  = 4'hE,
   parameter logic [3:0] OP_DIV   = 4'hF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [15:0] req_a,
   input  logic [15:0] req_b,
   input  logic        abort,
   output logic        rsp_valid,
   output logic [15:0] rsp_result,
   output logic        rsp_err,
   output logic        busy,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [3:0]  alu_op,
   input  logic [15:0] alu_res
);

   typedef enum logic [2:0] {IDLE, ADDSUB, MUL, DIV, DONE} state_t;

   state_t      state_reg, state_next;
   logic [15:0] a_reg, a_next, b_reg, b_next;
   logic [3:0]  op_reg, op_next;
   logic [15:0] acc_reg, acc_next, mcand_reg, mcand_next, mplier_reg, mplier_next;
   logic [15:0] rem_reg, rem_next, quo_reg, quo_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic [15:0] result_reg, result_next;
   logic        err_reg, err_next, ovf_reg, ovf_next;
   logic        rsp_valid_reg;
   logic [15:0] alu_a_reg, alu_a_next, alu_b_reg, alu_b_next;
   logic [3:0]  alu_op_reg, alu_op_next;
   logic        step_ovf;
   logic [15:0] div_s;
   logic        div_take;

   // Shifted partial remainder; a set R[15] means the 17-bit value always exceeds b.
   assign div_s    = {rem_reg[14:0], quo_reg[15]};
   assign div_take = rem_reg[15] | (div_s >= b_reg);

`ifdef ALU_SEQ_OVF_EN
   always_comb begin
      step_ovf = 1'b0;
      case (state_reg)
         ADDSUB: step_ovf = (op_reg == OP_PLUS) ? (alu_res < a_reg) : (a_reg < b_reg);
         MUL:    step_ovf = ((alu_b_reg != 16'd0) && (alu_res < acc_reg)) ||
                            (mcand_reg[15] && ((mplier_reg >> 1) != 16'd0));
         default: step_ovf = 1'b0;
      endcase
   end
`else
   assign step_ovf = 1'b0;
`endif

   always_comb begin
      state_next  = state_reg;
      a_next      = a_reg;
      b_next      = b_reg;
      op_next     = op_reg;
      acc_next    = acc_reg;
      mcand_next  = mcand_reg;
      mplier_next = mplier_reg;
      rem_next    = rem_reg;
      quo_next    = quo_reg;
      cnt_next    = cnt_reg;
      result_next = result_reg;
      err_next    = err_reg;
      ovf_next    = ovf_reg | step_ovf;
      case (state_reg)
         IDLE: begin
            ovf_next = 1'b0;
            if (req_valid && !abort) begin
               a_next   = req_a;
               b_next   = req_b;
               op_next  = req_op;
               cnt_next = 4'd0;
               if (req_op == OP_PLUS || req_op == OP_MINUS) begin
                  state_next = ADDSUB;
               end else if (req_op == OP_MULT) begin
                  state_next  = MUL;
                  acc_next    = 16'd0;
                  mcand_next  = req_a;
                  mplier_next = req_b;
               end else if (req_op == OP_DIV && req_b != 16'd0) begin
                  state_next = DIV;
                  rem_next   = 16'd0;
                  quo_next   = req_a;
               end else begin
                  state_next  = DONE;
                  result_next = 16'd0;
                  err_next    = 1'b1;
               end
            end
         end
         ADDSUB: begin
            state_next  = DONE;
            result_next = alu_res;
            err_next    = ovf_next;
         end
         MUL: begin
            acc_next    = alu_res;
            mcand_next  = mcand_reg << 1;
            mplier_next = mplier_reg >> 1;
            cnt_next    = cnt_reg + 4'd1;
            if (cnt_reg == 4'd15) begin
               state_next  = DONE;
               result_next = alu_res;
               err_next    = ovf_next;
            end
         end
         DIV: begin
            rem_next = div_take ? alu_res : div_s;
            quo_next = {quo_reg[14:0], div_take};
            cnt_next = cnt_reg + 4'd1;
            if (cnt_reg == 4'd15) begin
               state_next  = DONE;
               result_next = {quo_reg[14:0], div_take};
               err_next    = 1'b0;
            end
         end
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (abort && state_reg != IDLE) begin
         state_next  = IDLE;
         result_next = result_reg;
         err_next    = err_reg;
      end
   end

   // ALU operands are registered, so they are derived from the upcoming state's values.
   always_comb begin
      alu_a_next  = 16'd0;
      alu_b_next  = 16'd0;
      alu_op_next = 4'd0;
      case (state_next)
         ADDSUB: begin
            alu_a_next  = a_next;
            alu_b_next  = b_next;
            alu_op_next = op_next;
         end
         MUL: begin
            alu_a_next  = acc_next;
            alu_b_next  = mplier_next[0] ? mcand_next : 16'd0;
            alu_op_next = OP_PLUS;
         end
         DIV: begin
            alu_a_next  = {rem_next[14:0], quo_next[15]};
            alu_b_next  = b_next;
            alu_op_next = OP_MINUS;
         end
         default: begin
            alu_a_next  = 16'd0;
            alu_b_next  = 16'd0;
            alu_op_next = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         a_reg         <= 16'd0;
         b_reg         <= 16'd0;
         op_reg        <= 4'd0;
         acc_reg       <= 16'd0;
         mcand_reg     <= 16'd0;
         mplier_reg    <= 16'd0;
         rem_reg       <= 16'd0;
         quo_reg       <= 16'd0;
         cnt_reg       <= 4'd0;
         result_reg    <= 16'd0;
         err_reg       <= 1'b0;
         ovf_reg       <= 1'b0;
         rsp_valid_reg <= 1'b0;
         alu_a_reg     <= 16'd0;
         alu_b_reg     <= 16'd0;
         alu_op_reg    <= 4'd0;
      end else begin
         state_reg     <= state_next;
         a_reg         <= a_next;
         b_reg         <= b_next;
         op_reg        <= op_next;
         acc_reg       <= acc_next;
         mcand_reg     <= mcand_next;
         mplier_reg    <= mplier_next;
         rem_reg       <= rem_next;
         quo_reg       <= quo_next;
         cnt_reg       <= cnt_next;
         result_reg    <= result_next;
         err_reg       <= err_next;
         ovf_reg       <= ovf_next;
         rsp_valid_reg <= (state_next == DONE);
         alu_a_reg     <= alu_a_next;
         alu_b_reg     <= alu_b_next;
         alu_op_reg    <= alu_op_next;
      end
   end

   assign req_ready  = (state_reg == IDLE);
   assign busy       = (state_reg != IDLE);
   assign rsp_valid  = rsp_valid_reg;
   assign rsp_result = result_reg;
   assign rsp_err    = err_reg;
   assign alu_a      = alu_a_reg;
   assign alu_b      = alu_b_reg;
   assign alu_op     = alu_op_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer with a behavioural ALU and arithmetic reference model.
// Expected overflow flags follow ALU_SEQ_OVF_EN when it is defined for the build.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_op = 4'd0;
   logic [15:0] req_a = 16'd0;
   logic [15:0] req_b = 16'd0;
   logic        abort = 1'b0;
   logic        rsp_valid;
   logic [15:0] rsp_result;
   logic        rsp_err;
   logic        busy;
   logic [15:0] alu_a, alu_b, alu_res;
   logic [3:0]  alu_op;

   int checks = 0;
   int failures = 0;
   logic [15:0] last_res = 16'd0;
   logic        last_err = 1'b0;

   always #5 clk = ~clk;

   // The shared calculator ALU: plus and minus only.
   assign alu_res = (alu_op == 4'hC) ? alu_a + alu_b :
                    (alu_op == 4'hD) ? alu_a - alu_b : 16'd0;

   alu_sequencer dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b), .abort(abort),
      .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: plain arithmetic on the request, not a step-by-step replay.
   task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] res, output logic err, output int lat);
      logic [31:0] full;
      logic        ovf;
      ovf = 1'b0;
      err = 1'b0;
      case (op)
         4'hC: begin full = {16'd0, a} + {16'd0, b}; res = full[15:0]; ovf = full[16]; lat = 2; end
         4'hD: begin res = a - b; ovf = (a < b); lat = 2; end
         4'hE: begin full = {16'd0, a} * {16'd0, b}; res = full[15:0]; ovf = (full[31:16] != 16'd0); lat = 17; end
         4'hF: begin
            if (b == 16'd0) begin res = 16'd0; err = 1'b1; lat = 1; end
            else begin res = a / b; lat = 17; end
         end
         default: begin res = 16'd0; err = 1'b1; lat = 1; end
      endcase
`ifdef ALU_SEQ_OVF_EN
      err = err | ovf;
`endif
   endtask

   task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input bit noisy);
      logic [15:0] exp_res, got_res;
      logic        exp_err, got_err, ready_after;
      int          exp_lat, got_lat, pulses;
      model(op, a, b, exp_res, exp_err, exp_lat);
      got_res = 16'hDEAD; got_err = 1'bx; got_lat = 0; pulses = 0; ready_after = 1'b0;
      @(negedge clk);
      check("ready_before", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
      for (int c = 1; c <= exp_lat + 2; c++) begin
         @(negedge clk);
         if (noisy && c < exp_lat) begin
            req_valid = 1'($urandom_range(0, 1));
            req_a = 16'($urandom);
         end else begin
            req_valid = 1'b0;
         end
         if (c == 1 && exp_lat > 1) check("busy", {31'd0, busy}, 32'd1);
         if (c == 1 && op == 4'hE) check("mul_alu_op", {28'd0, alu_op}, 32'hC);
         if (c == 1 && exp_lat == 17 && op == 4'hF) check("div_alu_op", {28'd0, alu_op}, 32'hD);
         if (rsp_valid) begin
            pulses++;
            got_lat = c; got_res = rsp_result; got_err = rsp_err;
         end
         if (c == exp_lat + 1) ready_after = req_ready;
      end
      $display("op=%h a=%h b=%h res=%h err=%b lat=%0d pulses=%0d", op, a, b, got_res, got_err, got_lat, pulses);
      check("latency", got_lat, exp_lat);
      check("pulses", pulses, 1);
      check("result", {16'd0, got_res}, {16'd0, exp_res});
      check("err", {31'd0, got_err}, {31'd0, exp_err});
      check("ready_after", {31'd0, ready_after}, 32'd1);
      last_res = exp_res;
      last_err = exp_err;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      int r;
      logic [3:0]  op;
      logic [15:0] a, b;

      repeat (3) @(negedge clk);
      check("reset_outs", {rsp_valid, rsp_err, busy, rsp_result, alu_op, alu_a[7:0]}, 32'd0);
      check("reset_alu", {alu_a, alu_b}, 32'd0);
      check("reset_ready", {31'd0, req_ready}, 32'd1);
      rst = 1'b0;

      run_op(4'hC, 16'h1234, 16'h0101, 1'b0);
      run_op(4'hD, 16'h0005, 16'h0007, 1'b0);
      run_op(4'hE, 16'd300, 16'd200, 1'b0);
      run_op(4'hE, 16'd300, 16'd300, 1'b0);
      run_op(4'hF, 16'd1000, 16'd7, 1'b0);
      run_op(4'hF, 16'hFFFF, 16'h8001, 1'b0);
      run_op(4'hF, 16'd5, 16'd0, 1'b0);
      run_op(4'h3, 16'd9, 16'd4, 1'b0);
      run_op(4'hE, 16'h1234, 16'h0011, 1'b1);

      // Abort on the fifth multiply step: nothing reported, previous response held.
      @(negedge clk);
      req_valid = 1'b1; req_op = 4'hE; req_a = 16'd300; req_b = 16'd200;
      pulses = 0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         req_valid = 1'b0;
         if (rsp_valid) pulses++;
         if (c == 5) abort = 1'b1;
      end
      @(negedge clk);
      abort = 1'b0;
      check("abort_idle", {30'd0, busy, req_ready}, 32'd1);
      for (int c = 0; c < 20; c++) begin
         if (rsp_valid) pulses++;
         @(negedge clk);
      end
      check("abort_no_rsp", pulses, 0);
      check("abort_held", {15'd0, rsp_err, rsp_result}, {15'd0, last_err, last_res});
      run_op(4'hC, 16'd2, 16'd3, 1'b0);

      // Abort together with a request in IDLE drops the request.
      @(negedge clk);
      req_valid = 1'b1; abort = 1'b1; req_op = 4'hC; req_a = 16'd7; req_b = 16'd8;
      @(negedge clk);
      req_valid = 1'b0; abort = 1'b0;
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
         if (rsp_valid || busy) pulses++;
         @(negedge clk);
      end
      check("idle_abort_drop", pulses, 0);

      // Reset in the middle of a divide.
      @(negedge clk);
      req_valid = 1'b1; req_op = 4'hF; req_a = 16'd1000; req_b = 16'd7;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         req_valid = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_outs", {rsp_valid, rsp_err, busy, rsp_result, alu_op, alu_a[7:0]}, 32'd0);
      check("rst_alu", {alu_a, alu_b}, 32'd0);
      check("rst_ready", {31'd0, req_ready}, 32'd1);
      pulses = 0;
      for (int c = 0; c < 20; c++) begin
         if (rsp_valid) pulses++;
         @(negedge clk);
      end
      check("rst_no_rsp", pulses, 0);
      last_res = 16'd0;
      last_err = 1'b0;

      for (int i = 0; i < 60; i++) begin
         r = int'($urandom_range(0, 9));
         a = 16'($urandom);
         b = 16'($urandom);
         case (r)
            0, 1: op = 4'hC;
            2, 3: op = 4'hD;
            4, 5: op = 4'hE;
            6, 7: op = 4'hF;
            8: begin op = 4'hF; b = 16'd0; end
            default: op = 4'($urandom_range(0, 11));
         endcase
         if (op == 4'hE && $urandom_range(0, 1) == 1) begin
            a = a & 16'h00FF;
            b = b & 16'h00FF;
         end
         if (op == 4'hF && r != 8 && $urandom_range(0, 2) == 0) b = b & 16'h000F;
         run_op(op, a, b, bit'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Sequences the shared 16-bit calculator ALU on behalf of the main keypad FSB. It accepts one operation request at a time over a valid/ready handshake. Add and subtract take a single ALU pass. Multiply and divide are built as 16-step shift-add and restoring-division loops that reuse the ALU's plus and minus operations. The result is returned as a one-cycle response pulse, with the result held for display.

Parameters:
OP_PLUS, 4'hC, ALU/key code for add
OP_MINUS, 4'hD, ALU/key code for subtract
OP_MULT, 4'hE, request code for multiply (never driven to the ALU)
OP_DIV, 4'hF, request code for divide (never driven to the ALU)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_op  in  4  operation code
req_a  in  16  operand 1 (dividend / multiplicand)
req_b  in  16  operand 2 (divisor / multiplier)
abort  in  1  synchronous cancel (AC key)
rsp_valid  out  1  one-cycle completion pulse
rsp_result  out  16  result, held until next accept
rsp_err  out  1  error flag, held with rsp_result
busy  out  1  high when not IDLE
alu_a, alu_b  out  16  registered ALU operands
alu_op  out  4  registered ALU opcode
alu_res  in  16  combinational ALU result, valid in the same cycle as alu_a/alu_b/alu_op

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset: state=IDLE; every output and internal register is 0, except req_ready=1.
- Priority: rst > abort > normal operation.
- States: IDLE, ADDSUB, MUL, DIV, DONE.
- Accept: in IDLE when req_valid=1, registers the operands and op. req_valid outside IDLE is ignored; nothing is queued.
- Routing on accept:
  - PLUS/MINUS -> ADDSUB.
  - MULT -> MUL, with cnt=0, acc=0, mcand=req_a, mplier=req_b.
  - DIV with req_b!=0 -> DIV, with R=0, Q=req_a, cnt=0.
  - DIV with req_b==0 -> DONE, result 0x0000, err=1.
  - Any other op -> DONE, result 0x0000, err=1.
- ADDSUB (1 cycle): alu_a=a, alu_b=b, alu_op=op. alu_res is captured as the result -> DONE.
- MUL step, repeated 16 times:
  - alu_a=acc, alu_b=mplier[0]?mcand:0, alu_op=OP_PLUS.
  - acc<=alu_res; mcand<<=1; mplier>>=1; cnt++.
  - After cnt=15 -> DONE with result=acc.
- DIV step, repeated 16 times (restoring division):
  - s={R[14:0],Q[15]}; alu_a=s, alu_b=b, alu_op=OP_MINUS.
  - If R[15]==1 or s>=b (unsigned, local compare): R<=alu_res and Q<={Q[14:0],1}.
  - Otherwise: R<=s and Q<={Q[14:0],0}.
  - After 16 steps -> DONE with result=Q. The remainder is discarded.
- DONE: rsp_valid=1 for exactly this cycle; rsp_result/rsp_err update here. Next state IDLE.
- Latency from accept edge to rsp_valid: add/sub 2 cycles; mul/div 17 cycles; error cases 1 cycle. req_ready is high again the cycle after rsp_valid.
- Idle ALU drive: in IDLE and DONE, alu_a=alu_b=0 and alu_op=0.
- abort:
  - In any non-IDLE state: -> IDLE next cycle, no rsp_valid, rsp_result/rsp_err unchanged.
  - In IDLE: no effect. An abort and a req_valid in the same IDLE cycle: the request is dropped.
- rst mid-operation: same as reset; no rsp_valid.
- Arithmetic: all arithmetic is unsigned, modulo 2^16; operands are treated as opaque 16-bit values.

Optional Feature:
ALU_SEQ_OVF_EN
- Defined: rsp_err is additionally set on overflow. The flag is sticky within an operation.
  - PLUS: alu_res < a.
  - MINUS: a < b.
  - MUL step: alu_res < acc with nonzero alu_b, or mcand[15]==1 while (mplier>>1)!=0.
- The result is still the modulo-2^16 value.
- Undefined: rsp_err is set only for divide-by-zero and illegal op.

Test Plan:
- PLUS a=0x1234 b=0x0101 -> rsp_valid 2 cycles after accept, result 0x1335, err 0; MINUS 0x0005-0x0007 -> 0xFFFE, err 1 only with ALU_SEQ_OVF_EN.
- MULT 300*200 -> rsp_valid at cycle 17, result 0xEA60, err 0; MULT 300*300 -> result 0x5F90, err 1 with OVF_EN, 0 without.
- DIV 1000/7 -> result 0x008E at cycle 17, err 0; DIV 0xFFFF/0x8001 -> 0x0001; DIV 5/0 -> result 0x0000, err 1, rsp_valid at cycle 1.
- Abort on step 5 of MULT -> IDLE next cycle, no rsp_valid, previous result held; next PLUS 2+3 returns 0x0005.
- rst asserted mid-DIV -> next cycle all outputs 0, req_ready 1, no rsp_valid.
- req_op=0x3 -> err 1, result 0, latency 1; req_valid pulses during a MULT are ignored and exactly one rsp_valid is seen.
